// File: rtl/jstk_spi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jstk_spi_ctrl_pkg
//   Shared definitions for the PmodJSTK SPI master: controller state
//   encoding, command byte prefix, transfer length and the per-byte
//   transmit pattern.
// ---------------------------------------------------------------------------
package jstk_spi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } jstk_state_t;

   localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;
   localparam int         JSTK_NBYTES     = 5;
   localparam int         JSTK_BITS       = 8;

   // Byte 0 carries the LED command; the remaining bytes are dummies that
   // only clock the joystick's reply out.
   function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx,
                                               input logic [1:0] cmd);
      return (idx == 3'd0) ? {JSTK_CMD_PREFIX, cmd} : 8'h00;
   endfunction

   function automatic int jstk_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/jstk_spi_byte.sv
// ---------------------------------------------------------------------------
// jstk_spi_byte
//   8-bit SPI mode-0 shift engine, MSB first, SCLK half-period SCLK_HALF clks.
//   Ports:
//     clk, clr        clock, asynchronous active-low reset
//     start           begin a byte on this edge (ignored while busy)
//     tx_byte         byte to send, sampled with start
//     miso            serial input, captured on the edge that raises sclk
//     busy            a byte is in progress
//     done            high during the final clk cycle of the byte, so the
//                     caller can chain the next step on the same edge
//     rx_byte         received byte, complete while done is high
//     sclk, mosi      serial clock and data out
// ---------------------------------------------------------------------------
module jstk_spi_byte
   import jstk_spi_ctrl_pkg::*;
#(
   parameter int SCLK_HALF = 100
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic       sclk,
   output logic       mosi
);

   localparam int HW = $clog2(SCLK_HALF + 1);

   logic          busy_reg;
   logic          sclk_reg;
   logic          mosi_reg;
   logic [7:0]    tx_reg;
   logic [7:0]    rx_reg;
   logic [2:0]    bit_reg;
   logic [HW-1:0] half_reg;
   logic          half_last;

   assign half_last = (half_reg == HW'(SCLK_HALF - 1));

   // Last cycle of the high phase of the last bit.
   assign done    = busy_reg && sclk_reg && half_last && (bit_reg == 3'(JSTK_BITS - 1));
   assign busy    = busy_reg;
   assign rx_byte = rx_reg;
   assign sclk    = sclk_reg;
   assign mosi    = mosi_reg;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         busy_reg <= 1'b0;
         sclk_reg <= 1'b0;
         mosi_reg <= 1'b0;
         tx_reg   <= '0;
         rx_reg   <= '0;
         bit_reg  <= '0;
         half_reg <= '0;
      end else if (start && !busy_reg) begin
         // First low phase begins now, so the MSB goes out immediately.
         busy_reg <= 1'b1;
         sclk_reg <= 1'b0;
         mosi_reg <= tx_byte[7];
         tx_reg   <= {tx_byte[6:0], 1'b0};
         bit_reg  <= '0;
         half_reg <= '0;
      end else if (busy_reg) begin
         if (!half_last) begin
            half_reg <= half_reg + 1'b1;
         end else begin
            half_reg <= '0;
            if (!sclk_reg) begin
               sclk_reg <= 1'b1;
               rx_reg   <= {rx_reg[6:0], miso};
            end else begin
               sclk_reg <= 1'b0;
               if (bit_reg == 3'(JSTK_BITS - 1)) begin
                  busy_reg <= 1'b0;
                  mosi_reg <= 1'b0;
               end else begin
                  bit_reg  <= bit_reg + 3'd1;
                  mosi_reg <= tx_reg[7];
                  tx_reg   <= {tx_reg[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// ---------------------------------------------------------------------------
// jstk_spi_ctrl
//   PmodJSTK SPI master. Every POLL_PERIOD idle cycles it runs a 5-byte
//   transfer (LED command out, X/Y/buttons in) and publishes the result as
//   one snapshot with a single-cycle pos_valid strobe.
//   Ports:
//     clk, clr             100 MHz clock, asynchronous active-low reset
//     led_cmd[1:0]         LED bits, latched at the start of each transfer
//     MISO                 joystick data in
//     SS, SCLK, MOSI       slave select (active low), SPI clock, data out
//     x_pos, y_pos[9:0]    joystick position
//     btns[2:0]            {btn2, btn1, trigger}
//     pos_valid            pulses for one cycle when the outputs update
// ---------------------------------------------------------------------------
module jstk_spi_ctrl
   import jstk_spi_ctrl_pkg::*;
#(
   parameter int SCLK_HALF   = 100,
   parameter int SS_SETUP    = 1500,
   parameter int BYTE_GAP    = 1000,
   parameter int POLL_PERIOD = 1000000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] led_cmd,
   input  logic       MISO,
   output logic       SS,
   output logic       SCLK,
   output logic       MOSI,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic [2:0] btns,
   output logic       pos_valid
);

   localparam int CNT_W = $clog2(jstk_max3(POLL_PERIOD, SS_SETUP, BYTE_GAP) + 1);

   jstk_state_t  state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]   byte_idx_reg;
   logic [1:0]   cmd_reg;
   logic [7:0]   x_lo_reg, y_lo_reg;
   logic [1:0]   x_hi_reg, y_hi_reg;
   logic [9:0]   x_pos_reg, y_pos_reg;
   logic [2:0]   btns_reg;
   logic         pos_valid_reg;

   logic         byte_start;
   logic         byte_busy;
   logic         byte_done;
   logic [7:0]   tx_byte;
   logic [7:0]   rx_byte;
   logic         ss_n;

   assign tx_byte = jstk_tx_byte(byte_idx_reg, cmd_reg);

   jstk_spi_byte #(
      .SCLK_HALF (SCLK_HALF)
   ) u_byte (
      .clk     (clk),
      .clr     (clr),
      .start   (byte_start),
      .tx_byte (tx_byte),
      .miso    (MISO),
      .busy    (byte_busy),
      .done    (byte_done),
      .rx_byte (rx_byte),
      .sclk    (SCLK),
      .mosi    (MOSI)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   // Byte starts are issued on the last cycle of SETUP/GAP so that the
   // shift engine begins on the very edge the state changes: SS stays low
   // for exactly SS_SETUP + 80*SCLK_HALF + 4*BYTE_GAP cycles.
   always_comb begin
      state_next = state_reg;
      byte_start = 1'b0;
      ss_n       = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            if (cnt_reg == CNT_W'(POLL_PERIOD - 1)) state_next = ST_SETUP;
         end
         ST_SETUP: begin
            ss_n = 1'b0;
            if (cnt_reg == CNT_W'(SS_SETUP - 1) && !byte_busy) begin
               byte_start = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ss_n = 1'b0;
            if (byte_done) begin
               if (byte_idx_reg == 3'(JSTK_NBYTES - 1)) state_next = ST_DONE;
               else                                     state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            ss_n = 1'b0;
            if (cnt_reg == CNT_W'(BYTE_GAP - 1) && !byte_busy) begin
               byte_start = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_reg       <= '0;
         byte_idx_reg  <= '0;
         cmd_reg       <= '0;
         x_lo_reg      <= '0;
         x_hi_reg      <= '0;
         y_lo_reg      <= '0;
         y_hi_reg      <= '0;
         x_pos_reg     <= '0;
         y_pos_reg     <= '0;
         btns_reg      <= '0;
         pos_valid_reg <= 1'b0;
      end else begin
         pos_valid_reg <= 1'b0;

         // Counters only run in the timed states and restart on every
         // state change, so they never wrap.
         if (state_next != state_reg)
            cnt_reg <= '0;
         else if (state_reg == ST_IDLE || state_reg == ST_SETUP || state_reg == ST_GAP)
            cnt_reg <= cnt_reg + 1'b1;

         if (state_reg == ST_IDLE && state_next == ST_SETUP) begin
            cmd_reg      <= led_cmd;
            byte_idx_reg <= '0;
         end

         // Received bytes are staged privately; the visible outputs only
         // change together as the last byte completes (entering DONE).
         if (state_reg == ST_SHIFT && byte_done) begin
            byte_idx_reg <= byte_idx_reg + 3'd1;
            case (byte_idx_reg)
               3'd0: x_lo_reg <= rx_byte;
               3'd1: x_hi_reg <= rx_byte[1:0];
               3'd2: y_lo_reg <= rx_byte;
               3'd3: y_hi_reg <= rx_byte[1:0];
               default: begin
                  x_pos_reg     <= {x_hi_reg, x_lo_reg};
                  y_pos_reg     <= {y_hi_reg, y_lo_reg};
                  btns_reg      <= rx_byte[2:0];
                  pos_valid_reg <= 1'b1;
               end
            endcase
         end
      end
   end

   assign SS        = ss_n;
   assign x_pos     = x_pos_reg;
   assign y_pos     = y_pos_reg;
   assign btns      = btns_reg;
   assign pos_valid = pos_valid_reg;

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jstk_spi_ctrl
//   Self-checking bench for jstk_spi_ctrl with small timing parameters.
//   The reference model describes a transfer as a timeline: the position
//   inside one poll period determines SS/SCLK/MOSI by plain arithmetic, and
//   the snapshot outputs follow from the bytes the joystick model returned.
// ---------------------------------------------------------------------------
module tb_jstk_spi_ctrl;

   localparam int SH = 2;
   localparam int SU = 6;
   localparam int GP = 4;
   localparam int PP = 20;
   localparam int LOW_LEN   = SU + 80*SH + 4*GP;   // 182
   localparam int PERIOD    = PP + LOW_LEN + 1;    // idle + SS low + DONE
   localparam int BYTE_SLOT = 16*SH + GP;

   logic       clk;
   logic       clr;
   logic [1:0] led_cmd;
   logic       MISO;
   logic       SS, SCLK, MOSI;
   logic [9:0] x_pos, y_pos;
   logic [2:0] btns;
   logic       pos_valid;

   jstk_spi_ctrl #(
      .SCLK_HALF   (SH),
      .SS_SETUP    (SU),
      .BYTE_GAP    (GP),
      .POLL_PERIOD (PP)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .led_cmd   (led_cmd),
      .MISO      (MISO),
      .SS        (SS),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .x_pos     (x_pos),
      .y_pos     (y_pos),
      .btns      (btns),
      .pos_valid (pos_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model state
   int         k;          // clock edges since reset release
   int         p;          // position within the poll period
   logic [1:0] model_cmd;
   logic [7:0] rxb [5];
   logic [7:0] plan [5];
   bit         plan_valid;
   logic [9:0] exp_x, exp_y;
   logic [2:0] exp_btns;
   logic       exp_valid;
   bit         rand_cmd;

   // observation of the serial side
   int         ss_low_cnt, rise_cnt, valid_cnt;
   int         fall_k, rise0_k;
   logic [7:0] mosi_cap [5];
   logic       ss_prev, sclk_prev;
   int         xfer_no;

   int n_cmp, n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (k=%0d p=%0d t=%0t)", name, act, exp, k, p, $time);
      end
   endtask

   // Expected {SS, SCLK, MOSI} at position pp of the poll period.
   function automatic logic [2:0] exp_pins(input int pp, input logic [1:0] cmd);
      int q, r, b, o;
      logic [7:0] tx;
      if (pp < PP || pp >= PP + LOW_LEN) return 3'b100;
      q = pp - PP;
      if (q < SU) return 3'b000;
      r = q - SU;
      b = r / BYTE_SLOT;
      o = r % BYTE_SLOT;
      if (o >= 16*SH) return 3'b000;
      tx = (b == 0) ? {6'b100000, cmd} : 8'h00;
      return {1'b0, (o % (2*SH)) >= SH, tx[7 - o/(2*SH)]};
   endfunction

   task automatic sample_and_check();
      p = k % PERIOD;
      if (p == PP) begin
         model_cmd = led_cmd;
         for (int i = 0; i < 5; i++) rxb[i] = plan_valid ? plan[i] : 8'($urandom);
         plan_valid = 1'b0;
      end
      exp_valid = (p == PERIOD - 1);
      if (exp_valid) begin
         exp_x    = {rxb[1][1:0], rxb[0]};
         exp_y    = {rxb[3][1:0], rxb[2]};
         exp_btns = rxb[4][2:0];
      end
      chk("pins", 32'({SS, SCLK, MOSI}), 32'(exp_pins(p, model_cmd)));
      chk("outs", 32'({x_pos, y_pos, btns, pos_valid}), 32'({exp_x, exp_y, exp_btns, exp_valid}));

      if (!SS && ss_prev) begin
         ss_low_cnt = 0;
         rise_cnt   = 0;
         valid_cnt  = 0;
         fall_k     = k;
         for (int i = 0; i < 5; i++) mosi_cap[i] = 8'h00;
      end
      if (!SS) ss_low_cnt++;
      if (SCLK && !sclk_prev) begin
         if (rise_cnt == 0) rise0_k = k;
         if (rise_cnt < 40) mosi_cap[rise_cnt/8] = {mosi_cap[rise_cnt/8][6:0], MOSI};
         rise_cnt++;
      end
      if (pos_valid) begin
         valid_cnt++;
         xfer_no++;
         $display("xfer %0d: cmd=%b x=%h y=%h btns=%b", xfer_no, model_cmd, x_pos, y_pos, btns);
      end
      ss_prev   = SS;
      sclk_prev = SCLK;
   endtask

   // Joystick model: present the reply bit only on the edge that raises
   // SCLK; any other time MISO carries noise.
   task automatic drive_next();
      int pn, r, o;
      pn = (k + 1) % PERIOD;
      MISO = 1'($urandom);
      if (pn >= PP + SU && pn < PP + LOW_LEN) begin
         r = pn - PP - SU;
         o = r % BYTE_SLOT;
         if (o < 16*SH && (o % (2*SH)) == SH)
            MISO = rxb[r / BYTE_SLOT][7 - o/(2*SH)];
      end
      if (rand_cmd && $urandom_range(0, 49) == 0) led_cmd = 2'($urandom);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      sample_and_check();
      drive_next();
   endtask

   task automatic run_until(input int target);
      int guard;
      guard = 0;
      while (p != target && guard < 2*PERIOD) begin
         step();
         guard++;
      end
      chk("run_until", 32'(p), 32'(target));
   endtask

   // Called one time unit after a posedge; the next posedge is edge 1.
   task automatic release_reset();
      clr        = 1'b1;
      k          = 0;
      exp_x      = '0;
      exp_y      = '0;
      exp_btns   = '0;
      plan_valid = 1'b0;
      ss_prev    = 1'b1;
      sclk_prev  = 1'b0;
      sample_and_check();
      drive_next();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; xfer_no = 0;
      k = 0; p = 0; rand_cmd = 1'b0; model_cmd = 2'b00;
      ss_low_cnt = 0; rise_cnt = 0; valid_cnt = 0; fall_k = 0; rise0_k = 0;
      for (int i = 0; i < 5; i++) begin rxb[i] = 8'h00; mosi_cap[i] = 8'h00; end
      clr = 1'b0; led_cmd = 2'b00; MISO = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pins", 32'({SS, SCLK, MOSI}), 32'h4);
      chk("reset_outs", 32'({x_pos, y_pos, btns, pos_valid}), 32'h0);

      // transfer 1: known reply, LEDs on
      @(posedge clk);
      #1;
      led_cmd = 2'b11;
      plan[0] = 8'hA5; plan[1] = 8'h02; plan[2] = 8'h3C; plan[3] = 8'h01; plan[4] = 8'h05;
      release_reset();
      plan_valid = 1'b1;
      run_until(PERIOD - 1);
      chk("t1_x", 32'(x_pos), 32'h2A5);
      chk("t1_y", 32'(y_pos), 32'h13C);
      chk("t1_btns", 32'(btns), 32'h5);
      chk("t1_valid", 32'(pos_valid), 32'h1);
      chk("t1_mosi0", 32'(mosi_cap[0]), 32'h83);
      for (int i = 1; i < 5; i++) chk("t1_mosi_dummy", 32'(mosi_cap[i]), 32'h00);
      chk("t1_ss_fall", 32'(fall_k), 32'd20);
      chk("t1_first_rise", 32'(rise0_k - fall_k), 32'd8);
      step();
      chk("t1_ss_low_len", 32'(ss_low_cnt), 32'd182);
      chk("t1_rises", 32'(rise_cnt), 32'd40);
      chk("t1_valid_pulses", 32'(valid_cnt), 32'd1);

      // transfer 2: upper junk bits set, LED command changed mid-transfer
      led_cmd = 2'b00;
      plan[0] = 8'h12; plan[1] = 8'hFF; plan[2] = 8'h34; plan[3] = 8'hFE; plan[4] = 8'hFF;
      plan_valid = 1'b1;
      run_until(60);
      led_cmd = 2'b01;
      run_until(PERIOD - 1);
      chk("t2_x", 32'(x_pos), 32'h312);
      chk("t2_y", 32'(y_pos), 32'h234);
      chk("t2_btns", 32'(btns), 32'h7);
      chk("t2_mosi0", 32'(mosi_cap[0]), 32'h80);

      // transfer 3: new LED command applies, then reset during byte 2
      step();
      run_until(PP + SU + 2*BYTE_SLOT + 10);
      chk("t3_mosi0", 32'(mosi_cap[0]), 32'h81);
      chk("t3_ss_low", 32'(SS), 32'h0);
      #2;
      clr = 1'b0;
      #1;
      chk("mid_rst_ss", 32'(SS), 32'h1);
      chk("mid_rst_sclk", 32'(SCLK), 32'h0);
      chk("mid_rst_outs", 32'({x_pos, y_pos, btns, pos_valid}), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      release_reset();

      // transfer 4: fresh values after normal idle wait
      run_until(PERIOD - 1);
      step();
      chk("t4_valid_pulses", 32'(valid_cnt), 32'd1);
      chk("t4_ss_low_len", 32'(ss_low_cnt), 32'd182);

      // randomized transfers with LED command changing at random times
      rand_cmd = 1'b1;
      repeat (5*PERIOD) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
